// File: rtl/oo_pkg.sv
// Shared out-of-order core types: default result/tag widths and the CDB beat
// seen by the reservation stations.
package oo_pkg;

   localparam int CDB_DATA_W = 32;
   localparam int CDB_TAG_W  = 6;

   typedef logic [CDB_TAG_W-1:0] tag_t;

   typedef struct packed {
      logic                  valid;
      tag_t                  tag;
      logic [CDB_DATA_W-1:0] data;
   } cdb_t;

endpackage

// File: rtl/cdb_writeback_ready_table.sv
// Per-physical-tag ready bits: flush sets all, alloc clears, broadcast sets.
// Writes land on the clock edge; both query ports read the registered state.
module ready_table
   import oo_pkg::*;
#(
   parameter int TAG_W = CDB_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic [TAG_W-1:0] alloc_tag,
   input  logic             set_valid,
   input  logic [TAG_W-1:0] set_tag,
   input  logic [TAG_W-1:0] qa_tag,
   input  logic [TAG_W-1:0] qb_tag,
   output logic             qa_ready,
   output logic             qb_ready
);

   localparam int DEPTH = 1 << TAG_W;

   logic [DEPTH-1:0] rdy_q;
   logic [DEPTH-1:0] rdy_d;

   // Alloc is applied after the set so a same-tag alloc leaves the bit clear.
   always_comb begin
      rdy_d = rdy_q;
      if (flush) begin
         rdy_d = '1;
      end else begin
         if (set_valid)
            rdy_d[set_tag] = 1'b1;
         if (alloc_valid)
            rdy_d[alloc_tag] = 1'b0;
      end
      rdy_d[0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         rdy_q <= '1;
      else
         rdy_q <= rdy_d;
   end

   assign qa_ready = rdy_q[qa_tag];
   assign qb_ready = rdy_q[qb_tag];

endmodule

// File: rtl/cdb_writeback.sv
// Writeback: picks the arbiter's winner, registers it onto the CDB (1 cycle),
// updates the ready table and counts broadcasts. No backpressure; the arbiter stalls the loser.
module cdb_writeback
   import oo_pkg::*;
#(
   parameter int DATA_W = CDB_DATA_W,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [TAG_W-1:0]  alu_tag,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ls_valid,
   input  logic [TAG_W-1:0]  ls_tag,
   input  logic [DATA_W-1:0] ls_data,
   input  logic              sel_result,
   input  logic              flush,
   input  logic              alloc_valid,
   input  logic [TAG_W-1:0]  alloc_tag,
   input  logic [TAG_W-1:0]  qa_tag,
   input  logic [TAG_W-1:0]  qb_tag,
   output logic              qa_ready,
   output logic              qb_ready,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_data,
   output logic [CNT_W-1:0]  bcast_cnt
);

   logic              win_valid;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_data;
   logic              bcast;

   // Follow the arbiter blindly: an invalid selected source means no broadcast.
   assign win_valid = sel_result ? ls_valid : alu_valid;
   assign win_tag   = sel_result ? ls_tag   : alu_tag;
   assign win_data  = sel_result ? ls_data  : alu_data;
   assign bcast     = win_valid & ~flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
      end else begin
         cdb_valid <= bcast;
         if (win_valid) begin
            cdb_tag  <= win_tag;
            cdb_data <= win_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         bcast_cnt <= '0;
      else if (bcast && (bcast_cnt != '1))
         bcast_cnt <= bcast_cnt + CNT_W'(1);
   end

   ready_table #(
      .TAG_W (TAG_W)
   ) u_ready_table (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc_valid (alloc_valid),
      .alloc_tag   (alloc_tag),
      .set_valid   (win_valid),
      .set_tag     (win_tag),
      .qa_tag      (qa_tag),
      .qb_tag      (qb_tag),
      .qa_ready    (qa_ready),
      .qb_ready    (qb_ready)
   );

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed vector table, counter saturation on a
// 4-bit-counter instance, then random traffic against a reference model.
module tb_cdb_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, ls_valid, sel_result, flush, alloc_valid;
   logic [5:0]  alu_tag, ls_tag, alloc_tag, qa_tag, qb_tag;
   logic [31:0] alu_data, ls_data;

   logic        qa_ready, qb_ready, cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [15:0] bcast_cnt;

   logic        qa_ready_s, qb_ready_s, cdb_valid_s;
   logic [5:0]  cdb_tag_s;
   logic [31:0] cdb_data_s;
   logic [3:0]  bcast_cnt_s;

   always #5 clk = ~clk;

   cdb_writeback #(.DATA_W(32), .TAG_W(6), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data),
      .ls_valid(ls_valid), .ls_tag(ls_tag), .ls_data(ls_data),
      .sel_result(sel_result), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
      .qa_tag(qa_tag), .qb_tag(qb_tag),
      .qa_ready(qa_ready), .qb_ready(qb_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .bcast_cnt(bcast_cnt)
   );

   cdb_writeback #(.DATA_W(32), .TAG_W(6), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data),
      .ls_valid(ls_valid), .ls_tag(ls_tag), .ls_data(ls_data),
      .sel_result(sel_result), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
      .qa_tag(qa_tag), .qb_tag(qb_tag),
      .qa_ready(qa_ready_s), .qb_ready(qb_ready_s),
      .cdb_valid(cdb_valid_s), .cdb_tag(cdb_tag_s), .cdb_data(cdb_data_s),
      .bcast_cnt(bcast_cnt_s)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: ready flags per tag, last CDB beat, total broadcast count.
   bit          m_rdy [64];
   logic        m_v;
   logic [5:0]  m_t;
   logic [31:0] m_d;
   int          m_cnt;

   function automatic int sat(input int c, input int mx);
      return (c > mx) ? mx : c;
   endfunction

   task automatic model_step();
      logic        wv;
      logic [5:0]  wt;
      logic [31:0] wd;
      if (!rst) begin
         foreach (m_rdy[i]) m_rdy[i] = 1'b1;
         m_v = 1'b0; m_t = '0; m_d = '0; m_cnt = 0;
      end else begin
         if (sel_result) begin wv = ls_valid;  wt = ls_tag;  wd = ls_data;  end
         else            begin wv = alu_valid; wt = alu_tag; wd = alu_data; end
         m_v = wv && !flush;
         if (wv) begin m_t = wt; m_d = wd; end
         if (m_v) m_cnt++;
         if (flush) begin
            foreach (m_rdy[i]) m_rdy[i] = 1'b1;
         end else begin
            if (wv) m_rdy[wt] = 1'b1;
            if (alloc_valid && alloc_tag != 6'd0) m_rdy[alloc_tag] = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string ph);
      chk({ph, ".cdb_valid"}, cdb_valid, m_v);
      chk({ph, ".cdb_tag"},   cdb_tag,   m_t);
      chk({ph, ".cdb_data"},  cdb_data,  m_d);
      chk({ph, ".bcast_cnt"}, bcast_cnt, sat(m_cnt, 65535));
      chk({ph, ".bcast_cnt4"}, bcast_cnt_s, sat(m_cnt, 15));
      chk({ph, ".qa_ready"},  qa_ready,  m_rdy[qa_tag]);
      chk({ph, ".qb_ready"},  qb_ready,  m_rdy[qb_tag]);
   endtask

   typedef struct {
      logic rst; logic av; logic [5:0] at; logic [31:0] ad;
      logic lv; logic [5:0] lt; logic [31:0] ld;
      logic sel; logic fl; logic alv; logic [5:0] alt;
      logic [5:0] qa; logic [5:0] qb;
      logic ev; logic [5:0] et; logic [31:0] ed; int ecnt; logic eqa; logic eqb;
   } vec_t;

   function automatic vec_t mk(
      input logic r, input logic av, input logic [5:0] at, input logic [31:0] ad,
      input logic lv, input logic [5:0] lt, input logic [31:0] ld,
      input logic sel, input logic fl, input logic alv, input logic [5:0] alt,
      input logic [5:0] qa, input logic [5:0] qb,
      input logic ev, input logic [5:0] et, input logic [31:0] ed, input int ecnt,
      input logic eqa, input logic eqb);
      vec_t v;
      v.rst = r; v.av = av; v.at = at; v.ad = ad; v.lv = lv; v.lt = lt; v.ld = ld;
      v.sel = sel; v.fl = fl; v.alv = alv; v.alt = alt; v.qa = qa; v.qb = qb;
      v.ev = ev; v.et = et; v.ed = ed; v.ecnt = ecnt; v.eqa = eqa; v.eqb = eqb;
      return v;
   endfunction

   task automatic drive_idle();
      rst = 1'b1; alu_valid = 0; alu_tag = 0; alu_data = 0;
      ls_valid = 0; ls_tag = 0; ls_data = 0; sel_result = 0; flush = 0;
      alloc_valid = 0; alloc_tag = 0; qa_tag = 0; qb_tag = 0;
   endtask

   vec_t vq[$];

   initial begin
      //          rst av at  ad       lv lt ld    sel fl alv alt qa  qb   ev et  ed       cnt qa qb
      vq.push_back(mk(0, 0, 0,  0,       0, 0, 0,    0, 0, 0, 0,  5,  63,  0, 0,  0,       0, 1, 1));
      vq.push_back(mk(0, 0, 0,  0,       0, 0, 0,    0, 0, 0, 0,  5,  63,  0, 0,  0,       0, 1, 1));
      vq.push_back(mk(1, 1, 7,  'hDEAD,  0, 0, 0,    0, 0, 0, 0,  7,  0,   1, 7,  'hDEAD,  1, 1, 1));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 1, 3,  3,  9,   0, 7,  'hDEAD,  1, 0, 1));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 1, 9,  3,  9,   0, 7,  'hDEAD,  1, 0, 0));
      vq.push_back(mk(1, 1, 3,  'h33,    1, 9, 'h99, 1, 0, 0, 0,  9,  3,   1, 9,  'h99,    2, 1, 0));
      vq.push_back(mk(1, 1, 3,  'h33,    0, 0, 0,    0, 0, 0, 0,  9,  3,   1, 3,  'h33,    3, 1, 1));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 0, 0,  3,  9,   0, 3,  'h33,    3, 1, 1));
      vq.push_back(mk(1, 1, 12, 'h12,    0, 0, 0,    0, 0, 1, 12, 12, 0,   1, 12, 'h12,    4, 0, 1));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 1, 0,  0,  12,  0, 12, 'h12,    4, 1, 0));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 1, 4,  4,  5,   0, 12, 'h12,    4, 0, 1));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 1, 5,  4,  5,   0, 12, 'h12,    4, 0, 0));
      vq.push_back(mk(1, 1, 4,  'h44,    0, 0, 0,    0, 1, 1, 6,  4,  5,   0, 4,  'h44,    4, 1, 1));
      vq.push_back(mk(1, 0, 0,  0,       0, 0, 0,    0, 0, 0, 0,  6,  12,  0, 4,  'h44,    4, 1, 1));
      vq.push_back(mk(1, 1, 20, 'h20,    0, 0, 0,    1, 0, 1, 30, 30, 20,  0, 4,  'h44,    4, 0, 1));
      vq.push_back(mk(0, 1, 21, 'h21,    0, 0, 0,    0, 0, 0, 0,  30, 21,  0, 0,  0,       0, 1, 1));

      drive_idle();
      foreach (vq[i]) begin
         rst = vq[i].rst; alu_valid = vq[i].av; alu_tag = vq[i].at; alu_data = vq[i].ad;
         ls_valid = vq[i].lv; ls_tag = vq[i].lt; ls_data = vq[i].ld;
         sel_result = vq[i].sel; flush = vq[i].fl;
         alloc_valid = vq[i].alv; alloc_tag = vq[i].alt;
         qa_tag = vq[i].qa; qb_tag = vq[i].qb;
         cycle();
         chk($sformatf("vec%0d.cdb_valid", i), cdb_valid, vq[i].ev);
         chk($sformatf("vec%0d.cdb_tag", i),   cdb_tag,   vq[i].et);
         chk($sformatf("vec%0d.cdb_data", i),  cdb_data,  vq[i].ed);
         chk($sformatf("vec%0d.bcast_cnt", i), bcast_cnt, vq[i].ecnt);
         chk($sformatf("vec%0d.qa_ready", i),  qa_ready,  vq[i].eqa);
         chk($sformatf("vec%0d.qb_ready", i),  qb_ready,  vq[i].eqb);
      end

      // 17 back-to-back broadcasts: the 4-bit counter must stop at 15.
      drive_idle();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      for (int i = 0; i < 17; i++) begin
         alu_valid = 1'b1; alu_tag = 6'(i + 1); alu_data = 32'(i * 3);
         cycle();
         chk($sformatf("sat%0d.bcast_cnt4", i), bcast_cnt_s, sat(i + 1, 15));
         chk($sformatf("sat%0d.bcast_cnt", i),  bcast_cnt,   i + 1);
      end
      alu_valid = 1'b0;
      cycle();
      chk("sat.hold", bcast_cnt_s, 15);

      // Random traffic; small tag pool half the time to force collisions.
      drive_idle();
      rst = 1'b0;
      cycle();
      for (int c = 0; c < 800; c++) begin
         rst         = ($urandom_range(0, 99) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         alu_valid   = $urandom_range(0, 1) == 1;
         ls_valid    = $urandom_range(0, 1) == 1;
         sel_result  = $urandom_range(0, 1) == 1;
         alloc_valid = $urandom_range(0, 1) == 1;
         alu_tag     = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         ls_tag      = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         alloc_tag   = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         alu_data    = $urandom;
         ls_data     = $urandom;
         qa_tag      = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         qb_tag      = 6'($urandom);
         cycle();
         check_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
